// File: rtl/fp_round_pkg.sv
// Shared types and width helpers for the FP round-to-integral unit and its
// sibling float/int converters.
package fp_round_pkg;

  typedef enum logic [2:0] {
    RM_RNE   = 3'd0,
    RM_TRUNC = 3'd1,
    RM_FLOOR = 3'd2,
    RM_CEIL  = 3'd3,
    RM_RNA   = 3'd4
  } rm_t;

  typedef enum logic [1:0] {
    CLS_NORMAL  = 2'd0,
    CLS_SMALL   = 2'd1,
    CLS_BIG     = 2'd2,
    CLS_SPECIAL = 2'd3
  } cls_t;

  typedef struct packed {
    logic inexact;
    logic invalid;
  } flags_t;

  function automatic int expw_of(input int fpwid);
    case (fpwid)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 15;
    endcase
  endfunction

  function automatic int fmsb_of(input int fpwid);
    return fpwid - expw_of(fpwid) - 2;
  endfunction

endpackage

// File: rtl/fp_round_int_if.sv
// Operand/result bus of the round-to-integral unit.
// A beat moves on a rising edge where valid && ready; the producer holds
// payload stable from raising valid until that edge, and ready may depend on valid.
interface fp_round_int_if #(parameter int FPWID = 128);
  logic             in_valid;
  logic             in_ready;
  logic [FPWID-1:0] i;
  logic [2:0]       rm;
  logic             out_valid;
  logic             out_ready;
  logic [FPWID-1:0] o;
  logic             inexact;
  logic             invalid;

  modport slave (
    input  in_valid, i, rm, out_ready,
    output in_ready, out_valid, o, inexact, invalid
  );

  modport master (
    output in_valid, i, rm, out_ready,
    input  in_ready, out_valid, o, inexact, invalid
  );
endinterface

// File: rtl/fp_round_int_core.sv
// Mask/guard/sticky/increment datapath: drops the low fb bits of a
// hidden-bit significand and rounds at bit fb; sum[FMSB+1] is the carry past the hidden bit.
module fp_round_int_core
  import fp_round_pkg::*;
#(
  parameter int FMSB = 111,
  parameter int EXPW = 15
) (
  input  logic            sign,
  input  logic [2:0]      rm,
  input  logic [FMSB+1:0] sig_h,
  input  logic [EXPW-1:0] fb,
  output logic [FMSB+1:0] sum,
  output logic            guard,
  output logic            sticky
);

  localparam logic [FMSB+1:0] ONE = {{(FMSB+1){1'b0}}, 1'b1};

  logic [FMSB+1:0] lsb_mask;
  logic [FMSB+1:0] low_mask;
  logic            lsb;
  logic            inc;

  always_comb begin
    lsb_mask = ONE << fb;
    low_mask = lsb_mask - ONE;
    guard    = |(sig_h & (lsb_mask >> 1));
    sticky   = |(sig_h & (low_mask >> 1));
    lsb      = |(sig_h & lsb_mask);
    case (rm)
      RM_RNE:   inc = guard && (sticky || lsb);
      RM_RNA:   inc = guard;
      RM_CEIL:  inc = !sign && (guard || sticky);
      RM_FLOOR: inc = sign && (guard || sticky);
      default:  inc = 1'b0;
    endcase
    // Rounding at the hidden bit (fb = FMSB+1) lands directly in the carry bit.
    sum = {1'b0, sig_h[FMSB:0] & ~low_mask[FMSB:0]} + (inc ? lsb_mask : '0);
  end

endmodule

// File: rtl/fp_round_int.sv
// Three-stage pipelined IEEE-754 round-to-integral: unpack/classify,
// round, normalise/flags, with full valid/ready backpressure and clock enable.
module fp_round_int
  import fp_round_pkg::*;
#(
  parameter int FPWID = 128
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  fp_round_int_if.slave  bus
);

  localparam int EXPW   = expw_of(FPWID);
  localparam int FMSB   = fmsb_of(FPWID);
  localparam int BIAS_I = (1 << (EXPW - 1)) - 1;

  localparam logic [EXPW-1:0] BIAS     = EXPW'(BIAS_I);
  localparam logic [EXPW-1:0] BIAS_M1  = EXPW'(BIAS_I - 1);
  localparam logic [EXPW-1:0] BIG_EXP  = EXPW'(BIAS_I + FMSB + 1);
  localparam logic [EXPW-1:0] EXP_ONES = '1;
  localparam logic [FMSB:0]   FRAC_0   = '0;

  typedef struct packed {
    logic            sign;
    cls_t            cls;
    logic [2:0]      rm;
    logic [EXPW-1:0] exp;
    logic [FMSB:0]   sig;
  } s1_t;

  typedef struct packed {
    logic            sign;
    cls_t            cls;
    logic [EXPW-1:0] exp;
    logic [FMSB:0]   sig;
    logic [FMSB+1:0] sum;
    logic            grd;
    logic            stk;
    logic            one;
    logic            zero;
  } s2_t;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             adv1, adv2, adv3;
  s1_t              u, s1_d, s1_q;
  s2_t              r, s2_d, s2_q;
  logic [FPWID-1:0] o_d, o_q;
  flags_t           fl_d, fl_q;
  logic [FMSB+1:0]  core_sum;
  logic             core_g, core_s;

  // Stall propagates back from the consumer one stage per level, same cycle.
  always_comb begin
    adv3 = ce && (!v3_q || bus.out_ready);
    adv2 = ce && (!v2_q || adv3);
    adv1 = ce && (!v1_q || adv2);
  end

  assign bus.in_ready = adv1;

  always_comb begin
    u      = '0;
    u.sign = bus.i[FPWID-1];
    u.exp  = bus.i[FPWID-2 -: EXPW];
    u.sig  = bus.i[FMSB:0];
    u.rm   = bus.rm;
    if (u.exp == EXP_ONES)     u.cls = CLS_SPECIAL;
    else if (u.exp >= BIG_EXP) u.cls = CLS_BIG;
    else if (u.exp < BIAS)     u.cls = CLS_SMALL;
    else                       u.cls = CLS_NORMAL;
    v1_d = adv1 ? bus.in_valid : v1_q;
    s1_d = (adv1 && bus.in_valid) ? u : s1_q;
  end

  fp_round_int_core #(.FMSB(FMSB), .EXPW(EXPW)) u_core (
    .sign   (s1_q.sign),
    .rm     (s1_q.rm),
    .sig_h  ({1'b1, s1_q.sig}),
    .fb     (BIG_EXP - s1_q.exp),
    .sum    (core_sum),
    .guard  (core_g),
    .sticky (core_s)
  );

  always_comb begin
    r      = '0;
    r.sign = s1_q.sign;
    r.cls  = s1_q.cls;
    r.exp  = s1_q.exp;
    r.sig  = s1_q.sig;
    r.sum  = core_sum;
    r.grd  = core_g;
    r.stk  = core_s;
    r.zero = (s1_q.exp == '0) && (s1_q.sig == '0);
    // |x| < 1 rounds to magnitude 1 or 0; this picks 1.
    case (s1_q.rm)
      RM_RNE:   r.one = (s1_q.exp == BIAS_M1) && (s1_q.sig != '0);
      RM_RNA:   r.one = (s1_q.exp == BIAS_M1);
      RM_CEIL:  r.one = !s1_q.sign;
      RM_FLOOR: r.one = s1_q.sign;
      default:  r.one = 1'b0;
    endcase
    v2_d = adv2 ? v1_q : v2_q;
    s2_d = (adv2 && v1_q) ? r : s2_q;
  end

  always_comb begin
    o_d  = o_q;
    fl_d = fl_q;
    if (adv3 && v2_q) begin
      fl_d = '0;
      case (s2_q.cls)
        CLS_NORMAL: begin
          o_d = s2_q.sum[FMSB+1] ? {s2_q.sign, s2_q.exp + EXPW'(1), FRAC_0}
                                 : {s2_q.sign, s2_q.exp, s2_q.sum[FMSB:0]};
          fl_d.inexact = s2_q.grd || s2_q.stk;
        end
        CLS_SMALL: begin
          o_d = {s2_q.sign, (s2_q.one && !s2_q.zero) ? BIAS : '0, FRAC_0};
          fl_d.inexact = !s2_q.zero;
        end
        CLS_BIG: o_d = {s2_q.sign, s2_q.exp, s2_q.sig};
        default: begin
          if (s2_q.sig != '0) begin
            o_d = {s2_q.sign, s2_q.exp, 1'b1, s2_q.sig[FMSB-1:0]};
            fl_d.invalid = !s2_q.sig[FMSB];
          end else begin
            o_d = {s2_q.sign, s2_q.exp, s2_q.sig};
          end
        end
      endcase
    end
    v3_d = adv3 ? v2_q : v3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      o_q  <= '0;
      fl_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      o_q  <= o_d;
      fl_q <= fl_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.o         = o_q;
  assign bus.inexact   = fl_q.inexact;
  assign bus.invalid   = fl_q.invalid;

endmodule
